// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stage boundaries.
// Holds the stage occupancy enum, default payload widths and the bit layout
// of the default EX->MEM payload (control bits and data-field offsets).
package pipe_pkg;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } pipe_state_e;

  localparam int unsigned CtrlWDefault = 6;
  localparam int unsigned DataWDefault = 133;

  // Control bit positions: {ALUequal, MemWrite, MemRead, MemtoReg[1:0], RegWrite}
  localparam int unsigned CTRL_ALUEQ      = 5;
  localparam int unsigned CTRL_MEMWR      = 4;
  localparam int unsigned CTRL_MEMRD      = 3;
  localparam int unsigned CTRL_MEM2REG_HI = 2;
  localparam int unsigned CTRL_MEM2REG_LO = 1;
  localparam int unsigned CTRL_REGWR      = 0;

  // Data field LSB offsets: {ALUout, memwritedata, PCplus4, PC, regwriteaddr}
  localparam int unsigned DATA_REGWRADDR_OFS = 0;
  localparam int unsigned DATA_REGWRADDR_W   = 5;
  localparam int unsigned DATA_PC_OFS        = 5;
  localparam int unsigned DATA_PCPLUS4_OFS   = 37;
  localparam int unsigned DATA_MEMWRDATA_OFS = 69;
  localparam int unsigned DATA_ALUOUT_OFS    = 101;
  localparam int unsigned DATA_WORD_W        = 32;

endpackage

// File: rtl/pipe_entry_reg.sv
// Single {ctrl, data} payload register used as one slot of a pipeline stage.
// Ports:
//   clk, reset      - clock, synchronous active-low reset (clears ctrl and data)
//   load            - capture ctrlIn/dataIn (takes priority over clrCtrl)
//   clrCtrl         - clear the ctrl field only; data is left untouched
//   ctrlIn, dataIn  - payload to load
//   ctrlOut, dataOut- registered payload
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CtrlWDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clrCtrl,
  input  logic [CTRL_W-1:0] ctrlIn,
  input  logic [DATA_W-1:0] dataIn,
  output logic [CTRL_W-1:0] ctrlOut,
  output logic [DATA_W-1:0] dataOut
);

  logic [CTRL_W-1:0] ctrlQ;
  logic [DATA_W-1:0] dataQ;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrlQ <= '0;
      dataQ <= '0;
    end else if (load) begin
      ctrlQ <= ctrlIn;
      dataQ <= dataIn;
    end else if (clrCtrl) begin
      ctrlQ <= '0;
    end
  end

  assign ctrlOut = ctrlQ;
  assign dataOut = dataQ;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with valid/ready handshake, 2-entry skid
// buffer and flush. Ctrl bits are cleared whenever a slot is vacated and are
// gated to zero on bubbles; data bits are never modified or cleared in transit.
// Ports:
//   clk, reset                      - clock, synchronous active-low reset
//   flush                           - squash held entries and this cycle's arrival
//   in_valid/in_ready/in_ctrl/in_data    - upstream handshake and payload
//   out_valid/out_ready/out_ctrl/out_data - downstream handshake and head payload
//   occupancy                       - entries held (0..2)
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CtrlWDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_e stateQ, stateD;

  logic              accept, pop;
  logic              mainLoad, mainFromSkid, mainClr;
  logic              skidLoad, skidClr;
  logic [CTRL_W-1:0] mainCtrlIn, mainCtrl, skidCtrl;
  logic [DATA_W-1:0] mainDataIn, mainData, skidData;

  // in_ready comes from registered state only, so out_ready never reaches it.
  assign in_ready  = (stateQ != StFull) && reset;
  assign out_valid = (stateQ != StEmpty);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ <= StEmpty;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD       = stateQ;
    mainLoad     = 1'b0;
    mainFromSkid = 1'b0;
    mainClr      = 1'b0;
    skidLoad     = 1'b0;
    skidClr      = 1'b0;
    if (flush) begin
      // Arrival is dropped (no load) but upstream still sees its handshake.
      stateD  = StEmpty;
      mainClr = 1'b1;
      skidClr = 1'b1;
    end else begin
      unique case (stateQ)
        StEmpty: begin
          if (accept) begin
            stateD   = StOne;
            mainLoad = 1'b1;
          end
        end
        StOne: begin
          if (accept && pop) begin
            mainLoad = 1'b1;
          end else if (accept) begin
            stateD   = StFull;
            skidLoad = 1'b1;
          end else if (pop) begin
            stateD  = StEmpty;
            mainClr = 1'b1;
          end
        end
        StFull: begin
          // No accept possible here: in_ready is low while full.
          if (pop) begin
            stateD       = StOne;
            mainLoad     = 1'b1;
            mainFromSkid = 1'b1;
            skidClr      = 1'b1;
          end
        end
        default: begin
          stateD  = StEmpty;
          mainClr = 1'b1;
          skidClr = 1'b1;
        end
      endcase
    end
  end

  assign mainCtrlIn = mainFromSkid ? skidCtrl : in_ctrl;
  assign mainDataIn = mainFromSkid ? skidData : in_data;

  pipe_entry_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .load    (mainLoad),
    .clrCtrl (mainClr),
    .ctrlIn  (mainCtrlIn),
    .dataIn  (mainDataIn),
    .ctrlOut (mainCtrl),
    .dataOut (mainData)
  );

  pipe_entry_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load    (skidLoad),
    .clrCtrl (skidClr),
    .ctrlIn  (in_ctrl),
    .dataIn  (in_data),
    .ctrlOut (skidCtrl),
    .dataOut (skidData)
  );

  assign out_ctrl  = out_valid ? mainCtrl : '0;
  assign out_data  = mainData;
  assign occupancy = stateQ;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int unsigned CW = 6;
  localparam int unsigned DW = 133;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int tests  = 0;
  int failed = 0;

  // Reference model: a FIFO of at most two payloads plus the last head data shown.
  logic [CW-1:0] mCtrl[$];
  logic [DW-1:0] mData[$];
  logic [DW-1:0] lastData = '0;

  pipe_stage_skid #(
    .CTRL_W (CW),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // One clock cycle: drive inputs, check in_ready, advance model and check outputs.
  task automatic step(input logic r, input logic f, input logic v, input logic [CW-1:0] c,
                      input logic [DW-1:0] d, input logic ordy, output logic accepted);
    logic mReady;
    logic pop;
    reset     = r;
    flush     = f;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    #1;
    mReady = r && (mCtrl.size() < 2);
    check_eq("in_ready", {191'b0, in_ready}, {191'b0, mReady});
    accepted = v && mReady;
    pop      = (mCtrl.size() > 0) && ordy;
    @(posedge clk);
    if (!r) begin
      mCtrl.delete();
      mData.delete();
      lastData = '0;
    end else if (f) begin
      mCtrl.delete();
      mData.delete();
    end else begin
      if (pop) begin
        void'(mCtrl.pop_front());
        void'(mData.pop_front());
      end
      if (accepted) begin
        mCtrl.push_back(c);
        mData.push_back(d);
      end
    end
    if (mCtrl.size() > 0) lastData = mData[0];
    #1;
    check_eq("out_valid", {191'b0, out_valid}, {191'b0, (mCtrl.size() > 0)});
    check_eq("out_ctrl", {186'b0, out_ctrl}, {186'b0, (mCtrl.size() > 0) ? mCtrl[0] : 6'h0});
    check_eq("out_data", {59'b0, out_data}, {59'b0, lastData});
    check_eq("occupancy", {190'b0, occupancy}, 192'(mCtrl.size()));
  endtask

  // Hold an entry upstream until it is accepted, with a bounded wait.
  task automatic offer(input logic [CW-1:0] c, input logic [DW-1:0] d, input logic ordy);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 8) begin
      step(1'b1, 1'b0, 1'b1, c, d, ordy, acc);
      n++;
    end
    if (!acc) check_eq("offer_timeout", 192'd0, 192'd1);
  endtask

  logic acc;

  initial begin
    // Reset with a valid upstream entry presented.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 6'h3F, rand_data(), 1'b0, acc);
    step(1'b1, 1'b0, 1'b0, 6'h00, '0, 1'b0, acc);

    // Streaming at full throughput.
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, 1'b1, 6'h21, DW'(k * 'h11), 1'b1, acc);
    step(1'b1, 1'b0, 1'b0, 6'h00, '0, 1'b1, acc);

    // Back-pressure: A and B absorbed, C held until space frees.
    offer(6'h01, DW'('hA), 1'b0);
    offer(6'h02, DW'('hB), 1'b0);
    step(1'b1, 1'b0, 1'b1, 6'h04, DW'('hC), 1'b0, acc);
    if (acc) check_eq("c_accepted_when_full", 192'd1, 192'd0);
    offer(6'h04, DW'('hC), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 6'h00, '0, 1'b1, acc);

    // Flush while full, with D arriving.
    offer(6'h11, DW'('hAA), 1'b0);
    offer(6'h12, DW'('hBB), 1'b0);
    step(1'b1, 1'b1, 1'b1, 6'h3F, DW'('hDD), 1'b0, acc);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 6'h00, '0, 1'b1, acc);

    // Simultaneous accept and pop in ONE.
    offer(6'h08, DW'('h1A), 1'b0);
    step(1'b1, 1'b0, 1'b1, 6'h10, DW'('h1B), 1'b1, acc);
    step(1'b1, 1'b0, 1'b0, 6'h00, '0, 1'b1, acc);

    // Reset mid-operation while full and flushing.
    offer(6'h3F, DW'('h55), 1'b0);
    offer(6'h3E, DW'('h66), 1'b0);
    step(1'b0, 1'b1, 1'b1, 6'h3F, DW'('h77), 1'b1, acc);
    offer(6'h00, DW'('h88), 1'b0);
    step(1'b1, 1'b0, 1'b0, 6'h00, '0, 1'b1, acc);

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 99) < 65), CW'($urandom), rand_data(),
           ($urandom_range(0, 99) < 55), acc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised elastic pipeline-stage register that generalises the fixed EX→MEM latch into a reusable stage boundary, with valid/ready handshake, a 2-entry skid buffer, and a flush input. Payload is split into a control field, forced to zero on bubbles and flushes, and a data field, held as-is. Instances sit between EX and MEM and at any other stage boundary that needs back-pressure or squash.

## Interface
- `CTRL_W`, 6: control bits; default = {ALUequal, MemWrite, MemRead, MemtoReg[1:0], RegWrite}.
- `DATA_W`, 133: data bits; default = ALUout, memwritedata, PCplus4, PC (4×32) + regwriteaddr (5).
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-low; sampled only on the rising edge of `clk`.
- `flush` in 1: squash every entry held or arriving this cycle.
- `in_valid` in 1: upstream entry present.
- `in_ready` out 1: stage can accept.
- `in_ctrl` in CTRL_W: upstream control bits.
- `in_data` in DATA_W: upstream data.
- `out_valid` out 1: head entry present.
- `out_ready` in 1: downstream consumes the head.
- `out_ctrl` out CTRL_W: head control bits; all zero whenever `out_valid`=0.
- `out_data` out DATA_W: head data.
- `occupancy` out 2: number of entries held, 0–2.

## Operation
- Storage: main entry (drives outputs) and skid entry. State is EMPTY (0), ONE (1), or FULL (2); `occupancy` encodes it directly.
- A transfer in (accept) happens when `in_valid`&`in_ready`. A transfer out (pop) happens when `out_valid`&`out_ready`.
- `in_ready` = (state≠FULL) & `reset`. It depends only on registered state, never on `out_ready`.
- `out_valid` = (state≠EMPTY).
- State transitions when `flush`=0:
  - EMPTY, accept: go to ONE, main←in.
  - ONE, accept & pop: stay ONE, main←in.
  - ONE, accept only: go to FULL, skid←in.
  - ONE, pop only: go to EMPTY.
  - FULL, pop: go to ONE, main←skid, skid ctrl←0.
  - No handshake: hold.
- `flush`=1:
  - Next state is EMPTY. Both ctrl fields ←0.
  - The entry accepted in the same cycle is discarded, and upstream still sees the handshake complete.
  - Flush overrides accept and pop. A pop in the flush cycle still counts as consumed by downstream.
- Bubble rule: whenever an entry slot is vacated, its ctrl is cleared. `out_ctrl` is gated by `out_valid`, so a bubble never writes memory or registers.
- Data fields are not cleared on pop or flush. `out_data` keeps its last value while `out_valid`=0.
- Order is strictly FIFO. No payload bit is modified in transit.

## Timing
- Reset (`reset`=0 at an edge):
  - state←EMPTY.
  - All ctrl and data registers ←0.
  - Outputs afterwards: `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0.
  - `in_ready`=0 while `reset` is low; it becomes 1 in the first cycle after release.
  - Reset mid-operation drops all entries and has priority over `flush` and handshakes.
- Latency: an accept at edge N into EMPTY gives `out_valid`=1 with that payload after edge N.
- Throughput is one entry per cycle with `out_ready` held high.
- Back-pressure: when `out_ready` drops, one further entry is absorbed into the skid and `in_ready` falls after that edge.
- `in_ready` recovers one cycle after the FULL→ONE pop.
- No combinational path from `out_ready` to `in_ready`. Outputs are purely registered, except the `out_ctrl` gating, which depends only on registered state.

## Structure
- Shared package `pipe_pkg` holds:
  - the state enum (EMPTY/ONE/FULL);
  - default `CTRL_W`/`DATA_W` constants;
  - control-bit index constants (`CTRL_ALUEQ`, `CTRL_MEMWR`, `CTRL_MEMRD`, `CTRL_MEM2REG` [1:0], `CTRL_REGWR`);
  - data-field offsets for ALUout, memwritedata, PCplus4, PC, regwriteaddr.
- One sub-module, `pipe_entry_reg`, is natural: a single {ctrl, data} register with load and ctrl-clear enables and synchronous active-low reset. It is instantiated twice (main, skid).
- The FSM and handshake logic live in the top module.

## Test plan
- Reset: drive `reset`=0 for 2 cycles with `in_valid`=1 and `in_ctrl`=6'h3F. Require `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0, and `in_ready`=0 throughout. Require `in_ready`=1 in the first cycle after release.
- Streaming: send 8 entries with data `k`×0x11 and ctrl=6'h21, with `out_ready`=1. Require each to appear in order exactly 1 cycle after acceptance, `occupancy`=1 steady, and no bubbles.
- Back-pressure: with `out_ready`=0, offer A, B, C. Require A and B accepted, `occupancy`=2, `in_ready`=0, and C held upstream. Raise `out_ready`: require A, then B, then C, in order, with none lost or duplicated.
- Flush in FULL: hold A and B, then assert `flush` with `in_valid`=1 (entry D). Require next cycle `occupancy`=0, `out_valid`=0, `out_ctrl`=0, and D never appears on the output.
- Simultaneous accept & pop in ONE: head A, `out_ready`=1, offer B. Require `occupancy` to stay at 1 and `out_data`=B the next cycle.
- Reset mid-operation: assert `reset`=0 while FULL with `flush`=1. Require the full reset state after the edge, with no stale ctrl on the first post-reset accept.
